sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Two-master, one-slave arbiter for the SRAM-like bus.
- Shares a single slave port between the fetch-side instruction interface and the EXE-stage data interface (req/wr/wstrb/addr/wdata, addr_ok, data_ok).
- Issues one request at a time with fixed data-over-instruction priority.
- Holds a granted request stable until the slave accepts it, and steers in-order responses back to their owners using an owner-ID FIFO.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unanswered transactions. Must be a power of 2, at least 2.
- OWIDTH, 2, log2(OUTSTANDING); width of the FIFO pointers.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request
- inst_addr  in  32  instruction address. Instruction requests are always reads.
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction read data valid
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  load done or store acknowledged
- data_rdata  out  32  load data
- s_req  out  1  slave request
- s_wr  out  1  slave write
- s_wstrb  out  4  slave strobes
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave response valid
- s_rdata  in  32  slave read data
- busy  out  1  FIFO non-empty or HOLD state

Behaviour:
- Reset (synchronous, active-high) gives: state IDLE, FIFO count 0, read/write pointers 0. busy=0 and all *_addr_ok and *_data_ok outputs are 0 in that cycle.
- State machine, registered:
  - IDLE → HOLD_D when data is selected, s_req=1 and s_addr_ok=0.
  - IDLE → HOLD_I on the same condition for instruction.
  - HOLD_x → IDLE on s_addr_ok=1.
  - An acceptance in IDLE keeps the state IDLE.
- Selection:
  - In IDLE, choose data if data_req=1, otherwise instruction if inst_req=1.
  - In HOLD_D, always choose data; in HOLD_I, always choose instruction. This applies even if the other master requests, so s_addr, s_wr, s_wstrb and s_wdata never change while s_req is high and unaccepted.
- Output drive: s_req = selected master's req AND NOT full.
- Instruction selected: s_wr=0, s_wstrb=0, s_wdata=0.
- Masters hold req and payload stable until addr_ok. Behaviour when a master drops req in HOLD is undefined, and the bench does not test it.
- Acceptance:
  - data_addr_ok = s_addr_ok AND s_req AND data selected. inst_addr_ok is the same with instruction selected.
  - Both are combinational, zero-cycle paths.
  - Only one master is accepted per cycle.
- Owner FIFO:
  - On acceptance, push owner bit (1=data, 0=inst) at the write pointer.
  - On s_data_ok with count>0, pop the head.
  - Push and pop in the same cycle leave count unchanged and are legal at any count, because push is blocked when full.
  - Pointers wrap modulo OUTSTANDING.
  - full = (count == OUTSTANDING). When full, s_req=0 and both addr_ok=0.
- Response routing is combinational:
  - data_data_ok = s_data_ok AND count>0 AND head==1.
  - inst_data_ok = s_data_ok AND count>0 AND head==0.
  - Both rdata outputs = s_rdata unconditionally.
  - Store responses are routed the same way as loads.
- Spurious s_data_ok with count==0 is ignored: no output, no pointer change.
- The slave returns responses in acceptance order, earliest the cycle after s_addr_ok.
- busy = (count != 0) OR (state != IDLE).
- Reset mid-transaction discards the FIFO and HOLD state. Late responses from the slave after reset are then ignored as spurious.

Test Plan:
- Simultaneous requests: inst_req=1 and data_req=1 (addr 0x1000_0004, wr=1, wstrb=4'b0011) with s_addr_ok=1 → s_addr=0x1000_0004, s_wstrb=4'b0011, data_addr_ok=1, inst_addr_ok=0. Next cycle, inst is accepted.
- Hold: inst_req (addr 0xBFC0_0000) with s_addr_ok=0 for 3 cycles; data_req rises in cycle 2 → s_addr stays 0xBFC0_0000. After s_addr_ok, data is issued in the following cycle.
- Ordering: accept inst, data, inst; slave returns s_rdata 0x11, 0x22, 0x33 on three consecutive cycles → inst_data_ok/0x11, data_data_ok/0x22, inst_data_ok/0x33.
- Full: with OUTSTANDING=4, accept 4 requests with no response → s_req=0 on the 5th. When s_data_ok and a pending request coincide, the pop frees a slot and the request issues the next cycle; count returns to 4.
- Spurious response: s_data_ok=1 with count=0 → both data_ok=0 and busy stays 0.
- Reset mid-operation: 2 outstanding plus HOLD_D, then reset for 1 cycle → busy=0. A subsequent s_data_ok produces no data_ok, and the next request is issued in IDLE.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle: request channel (req/wr/wstrb/addr/wdata), accept
// handshake (addr_ok) and in-order response channel (data_ok/rdata).
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-master (instruction fetch, EXE data) to one-slave SRAM-like arbiter.
// Data has fixed priority; a granted request is held until the slave accepts
// it, and an owner-ID FIFO steers in-order responses back to their master.
module sram_like_arbiter #(
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned OWIDTH      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  sram_like_arbiter_if.slave          inst,
  sram_like_arbiter_if.slave          data,
  sram_like_arbiter_if.master         s,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_D = 2'd1,
    HOLD_I = 2'd2
  } state_t;

  localparam logic [OWIDTH:0] FULL_CNT = (OWIDTH+1)'(OUTSTANDING);

  state_t            r_state;
  logic              r_owner [OUTSTANDING];
  logic [OWIDTH-1:0] r_wptr;
  logic [OWIDTH-1:0] r_rptr;
  logic [OWIDTH:0]   r_count;

  logic w_full;
  logic w_nonempty;
  logic w_sel_data;
  logic w_sel_inst;
  logic w_sel_req;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);

  // Grant selection: HOLD states pin the owner so the slave sees a stable request
  always_comb begin
    w_sel_data = 1'b0;
    w_sel_inst = 1'b0;
    unique case (r_state)
      HOLD_D:  w_sel_data = 1'b1;
      HOLD_I:  w_sel_inst = 1'b1;
      default: begin
        w_sel_data = data.req;
        w_sel_inst = !data.req && inst.req;
      end
    endcase
  end

  // Slave request drive; instruction transactions are always reads
  always_comb begin
    w_sel_req = 1'b0;
    s.wr      = 1'b0;
    s.wstrb   = '0;
    s.wdata   = '0;
    s.addr    = inst.addr;
    if (w_sel_data) begin
      w_sel_req = data.req;
      s.wr      = data.wr;
      s.wstrb   = data.wstrb;
      s.wdata   = data.wdata;
      s.addr    = data.addr;
    end else if (w_sel_inst) begin
      w_sel_req = inst.req;
    end
    s.req = w_sel_req && !w_full && !reset;
  end

  // Acceptance and response routing are zero-cycle combinational paths
  always_comb begin
    w_accept      = s.addr_ok && s.req;
    data.addr_ok  = w_accept && w_sel_data;
    inst.addr_ok  = w_accept && w_sel_inst;
    w_push        = data.addr_ok || inst.addr_ok;
    w_pop         = s.data_ok && w_nonempty && !reset;
    w_head        = r_owner[r_rptr];
    data.data_ok  = w_pop && w_head;
    inst.data_ok  = w_pop && !w_head;
    data.rdata    = s.rdata;
    inst.rdata    = s.rdata;
    busy          = !reset && (w_nonempty || (r_state != IDLE));
  end

  // Hold FSM: enter HOLD when a request is presented but not accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s.req && !s.addr_ok)
            r_state <= w_sel_data ? HOLD_D : HOLD_I;
        end
        HOLD_D, HOLD_I: begin
          if (s.addr_ok)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Owner FIFO storage (1 = data, 0 = inst); contents need no reset
  always_ff @(posedge clk) begin
    if (w_push)
      r_owner[r_wptr] <= w_sel_data;
  end

  // Owner FIFO pointers and occupancy; pointers wrap naturally at 2**OWIDTH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed stimulus with an owner
// scoreboard that predicts which master each slave response belongs to.
module tb_sram_like_arbiter;

  logic clk;
  logic reset;
  logic busy;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if s_if ();

  sram_like_arbiter #(
    .OUTSTANDING (4),
    .OWIDTH      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if.slave),
    .data  (data_if.slave),
    .s     (s_if.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_owner_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to the next drive point; the slave response strobe is one-shot
  task automatic next_cyc();
    @(negedge clk);
    s_if.data_ok = 1'b0;
  endtask

  task automatic clear_inputs();
    inst_if.req   = 1'b0;
    inst_if.wr    = 1'b0;
    inst_if.wstrb = '0;
    inst_if.addr  = '0;
    inst_if.wdata = '0;
    data_if.req   = 1'b0;
    data_if.wr    = 1'b0;
    data_if.wstrb = '0;
    data_if.addr  = '0;
    data_if.wdata = '0;
    s_if.addr_ok  = 1'b0;
    s_if.data_ok  = 1'b0;
    s_if.rdata    = '0;
  endtask

  // Drive one slave response and compare routing against the scoreboard head
  task automatic respond(input logic [31:0] rd);
    logic owner;
    s_if.data_ok = 1'b1;
    s_if.rdata   = rd;
    #1;
    if (exp_owner_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      owner = exp_owner_q.pop_front();
      check("data_data_ok", {31'd0, data_if.data_ok}, {31'd0, owner});
      check("inst_data_ok", {31'd0, inst_if.data_ok}, {31'd0, !owner});
      if (owner) check("data_rdata", data_if.rdata, rd);
      else       check("inst_rdata", inst_if.rdata, rd);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;

    // Reset state
    next_cyc();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_iaok", {31'd0, inst_if.addr_ok}, 32'd0);
    check("rst_daok", {31'd0, data_if.addr_ok}, 32'd0);
    next_cyc();
    reset = 1'b0;
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Simultaneous requests: data wins, inst follows next cycle
    next_cyc();
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0100;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.wstrb = 4'b0011;
    data_if.addr = 32'h1000_0004; data_if.wdata = 32'hDEAD_BEEF;
    s_if.addr_ok = 1'b1;
    #1;
    check("sim_addr",  s_if.addr, 32'h1000_0004);
    check("sim_wstrb", {28'd0, s_if.wstrb}, 32'h3);
    check("sim_wr",    {31'd0, s_if.wr}, 32'd1);
    check("sim_wdata", s_if.wdata, 32'hDEAD_BEEF);
    check("sim_daok",  {31'd0, data_if.addr_ok}, 32'd1);
    check("sim_iaok",  {31'd0, inst_if.addr_ok}, 32'd0);
    exp_owner_q.push_back(1'b1);
    next_cyc();
    data_if.req = 1'b0;
    #1;
    check("sim2_iaok",  {31'd0, inst_if.addr_ok}, 32'd1);
    check("sim2_addr",  s_if.addr, 32'h0000_0100);
    check("sim2_wr",    {31'd0, s_if.wr}, 32'd0);
    check("sim2_wstrb", {28'd0, s_if.wstrb}, 32'd0);
    check("sim2_wdata", s_if.wdata, 32'd0);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    clear_inputs();
    respond(32'hAAAA_0001);
    next_cyc();
    respond(32'hAAAA_0002);
    next_cyc();
    #1;
    check("sim_idle_busy", {31'd0, busy}, 32'd0);

    // Hold: inst pinned while unaccepted even after data requests
    next_cyc();
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000;
    #1;
    check("hold1_req",  {31'd0, s_if.req}, 32'd1);
    check("hold1_addr", s_if.addr, 32'hBFC0_0000);
    next_cyc();
    data_if.req = 1'b1; data_if.addr = 32'h0000_2000; data_if.wr = 1'b0;
    #1;
    check("hold2_addr", s_if.addr, 32'hBFC0_0000);
    check("hold2_daok", {31'd0, data_if.addr_ok}, 32'd0);
    check("hold2_busy", {31'd0, busy}, 32'd1);
    next_cyc();
    #1;
    check("hold3_addr", s_if.addr, 32'hBFC0_0000);
    next_cyc();
    s_if.addr_ok = 1'b1;
    #1;
    check("hold4_iaok", {31'd0, inst_if.addr_ok}, 32'd1);
    check("hold4_daok", {31'd0, data_if.addr_ok}, 32'd0);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    inst_if.req = 1'b0;
    #1;
    check("hold5_addr", s_if.addr, 32'h0000_2000);
    check("hold5_daok", {31'd0, data_if.addr_ok}, 32'd1);
    exp_owner_q.push_back(1'b1);
    next_cyc();
    clear_inputs();
    respond(32'hBBBB_0001);
    next_cyc();
    respond(32'hBBBB_0002);

    // Ordering: inst, data, inst then back-to-back responses
    next_cyc();
    s_if.addr_ok = 1'b1;
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0300;
    #1;
    check("ord_iaok1", {31'd0, inst_if.addr_ok}, 32'd1);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h0000_0400;
    #1;
    check("ord_daok", {31'd0, data_if.addr_ok}, 32'd1);
    exp_owner_q.push_back(1'b1);
    next_cyc();
    data_if.req = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0304;
    #1;
    check("ord_iaok2", {31'd0, inst_if.addr_ok}, 32'd1);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    clear_inputs();
    respond(32'h11);
    next_cyc();
    respond(32'h22);
    next_cyc();
    respond(32'h33);

    // Full: four accepted without response blocks the fifth
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      s_if.addr_ok = 1'b1;
      data_if.req  = 1'b1;
      data_if.addr = 32'h0000_5000 + 32'(i * 4);
      #1;
      check("full_fill_daok", {31'd0, data_if.addr_ok}, 32'd1);
      exp_owner_q.push_back(1'b1);
    end
    next_cyc();
    data_if.req = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_6000;
    #1;
    check("full_sreq", {31'd0, s_if.req}, 32'd0);
    check("full_iaok", {31'd0, inst_if.addr_ok}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    next_cyc();
    respond(32'hC0C0_0001);
    check("full_pop_sreq", {31'd0, s_if.req}, 32'd0);
    next_cyc();
    #1;
    check("freed_sreq", {31'd0, s_if.req}, 32'd1);
    check("freed_iaok", {31'd0, inst_if.addr_ok}, 32'd1);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    #1;
    check("refull_sreq", {31'd0, s_if.req}, 32'd0);
    inst_if.req = 1'b0;
    s_if.addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      respond(32'hC0C0_0010 + 32'(i));
    end
    next_cyc();
    #1;
    check("drain_busy", {31'd0, busy}, 32'd0);

    // Spurious response with an empty FIFO
    next_cyc();
    s_if.data_ok = 1'b1; s_if.rdata = 32'h5555_5555;
    #1;
    check("spur_ddok", {31'd0, data_if.data_ok}, 32'd0);
    check("spur_idok", {31'd0, inst_if.data_ok}, 32'd0);
    check("spur_busy", {31'd0, busy}, 32'd0);
    next_cyc();
    #1;
    check("spur_busy2", {31'd0, busy}, 32'd0);

    // Reset mid-operation: two outstanding plus HOLD_D
    next_cyc();
    s_if.addr_ok = 1'b1;
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_7000;
    next_cyc();
    inst_if.req = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h0000_7004;
    next_cyc();
    s_if.addr_ok = 1'b0;
    data_if.addr = 32'h0000_7008;
    next_cyc();
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_hold_addr", s_if.addr, 32'h0000_7008);
    reset = 1'b1;
    data_if.req = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    next_cyc();
    reset = 1'b0;
    #1;
    check("after_rst_busy", {31'd0, busy}, 32'd0);
    s_if.data_ok = 1'b1; s_if.rdata = 32'h7777_7777;
    #1;
    check("late_ddok", {31'd0, data_if.data_ok}, 32'd0);
    check("late_idok", {31'd0, inst_if.data_ok}, 32'd0);
    next_cyc();
    s_if.addr_ok = 1'b1;
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_8000;
    #1;
    check("post_iaok", {31'd0, inst_if.addr_ok}, 32'd1);
    check("post_addr", s_if.addr, 32'h0000_8000);
    exp_owner_q.push_back(1'b0);
    next_cyc();
    clear_inputs();
    respond(32'h8888_0001);
    next_cyc();
    #1;
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
